// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state encoding and sizing helpers shared by
// the multiply/divide unit and its bench.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake plus operands and HI/LO results
// between the control unit (master) and the multiply/divide unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, err, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, err, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier or,
// when MULDIV_DIV_EN is defined, the restoring divider.
// Multiply: acc = {partial product high, multiplier remainder}; operand is
// the multiplicand magnitude. Divide: acc = {remainder, dividend/quotient};
// operand is the divisor magnitude; the new quotient bit is returned on
// q_bit and left out of acc_next[0].
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] mul_sum;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;

    // Single shift-add or shift-subtract step selected by mode_div.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        q_bit     = mode_div & (rem_shift >= {1'b0, operand});
        rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, operand}) : rem_shift[WIDTH-1:0];
        if (mode_div) begin
            acc_next = {rem_next, acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_div;

    // Single shift-add step; no divide hardware in this build.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        q_bit    = 1'b0;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and
// MTHI/MTLO writes. Signed ops run on magnitudes and fix the sign in FIX.
// Define MULDIV_DIV_EN to include the divide datapath and DIV state;
// without it DIV/DIVU complete in one cycle with err=1.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [WIDTH-1:0]        hi_q, lo_q;
    logic                    load_mul, wr_hi, wr_lo, fix_en;
    logic [2*WIDTH-1:0]      acc_q, step_acc, prod_fix;
    logic [WIDTH-1:0]        opnd_q, hi_fix, lo_fix;
    logic                    neg_lo_q;
    logic                    step_qbit, step_mode, step_run;
    logic                    op_signed, a_neg, b_neg;
    logic signed [WIDTH-1:0] a_s, b_s;
`ifdef MULDIV_DIV_EN
    logic                    load_div;
    logic                    is_div_q, neg_hi_q;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign a_s       = signed'(bus.a);
    assign b_s       = signed'(bus.b);
    assign op_signed = ~bus.op[0];
    assign a_neg     = op_signed & (a_s < 0);
    assign b_neg     = op_signed & (b_s < 0);
    assign step_mode = (state_q == S_DIV);
    assign step_run  = (state_q == S_MUL) || (state_q == S_DIV);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .mode_div (step_mode),
        .acc_next (step_acc),
        .q_bit    (step_qbit)
    );

    // Next-state and handshake decode; start is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load_mul = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        fix_en   = 1'b0;
`ifdef MULDIV_DIV_EN
        load_div = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            load_mul = 1'b1;
                            busy_d   = 1'b1;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                            if (bus.b == '0) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                load_div = 1'b1;
                                busy_d   = 1'b1;
                                cnt_d    = CNT_W'(WIDTH);
                                state_d  = S_DIV;
                            end
`else
                            done_d = 1'b1;
                            err_d  = 1'b1;
`endif
                        end
                        OP_MTHI: begin
                            wr_hi  = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            wr_lo  = 1'b1;
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
`ifdef MULDIV_DIV_EN
            S_MUL, S_DIV: begin
`else
            S_MUL: begin
`endif
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_en  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sign correction of the finished product, or quotient and remainder.
    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            hi_fix = mag(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
            lo_fix = mag(acc_q[WIDTH-1:0], neg_lo_q);
        end
`endif
    end

    // Control state and architectural HI/LO; reset aborts and clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (fix_en) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
            if (wr_hi) begin
                hi_q <= bus.a;
            end
            if (wr_lo) begin
                lo_q <= bus.a;
            end
        end
    end

    // Iteration datapath: operand magnitudes and sign flags load on start,
    // then the accumulator advances one step per cycle.
    always_ff @(posedge clk) begin
        if (load_mul) begin
            opnd_q   <= mag(bus.a, a_neg);
            acc_q    <= {{WIDTH{1'b0}}, mag(bus.b, b_neg)};
            neg_lo_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (load_div) begin
            opnd_q   <= mag(bus.b, b_neg);
            acc_q    <= {{WIDTH{1'b0}}, mag(bus.a, a_neg)};
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            is_div_q <= 1'b1;
`endif
        end else if (step_run) begin
            acc_q <= step_acc | {{(2*WIDTH-1){1'b0}}, step_qbit};
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
